// File: rtl/bicubic_interp_2d_if.sv
// Handshake bundle for the bicubic engine: window/phase request channel and
// pixel result channel. With BICUBIC_BILINEAR_MODE_EN defined, a per-job
// bilinear select (in_mode) is carried on the request channel.
interface bicubic_interp_2d_if #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*DATA_W-1:0]  in_pix;
  logic [FRAC_W-1:0]     in_fx;
  logic [FRAC_W-1:0]     in_fy;
`ifdef BICUBIC_BILINEAR_MODE_EN
  logic                  in_mode;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_pix;

`ifdef BICUBIC_BILINEAR_MODE_EN
  modport master (output in_valid, in_pix, in_fx, in_fy, in_mode, out_ready,
                  input  in_ready, out_valid, out_pix);
  modport slave  (input  in_valid, in_pix, in_fx, in_fy, in_mode, out_ready,
                  output in_ready, out_valid, out_pix);
`else
  modport master (output in_valid, in_pix, in_fx, in_fy, out_ready,
                  input  in_ready, out_valid, out_pix);
  modport slave  (input  in_valid, in_pix, in_fx, in_fy, out_ready,
                  output in_ready, out_valid, out_pix);
`endif
endinterface

// File: rtl/bicubic_interp_2d.sv
// bicubic_interp_2d: one 2-D Catmull-Rom (a = -0.5) sample per job from a
// 4x4 window and phases (fx, fy). Sequence: WX weights, WY weights, four
// horizontal row passes, one vertical pass with round/clamp, then hold the
// result until the consumer takes it. Jobs never overlap.
// Optional feature macro: BICUBIC_BILINEAR_MODE_EN (adds in_mode, which
// swaps the cubic weights for bilinear ones with identical timing).
module bicubic_interp_2d #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bicubic_interp_2d_if.slave bus
);
  localparam int WW = FRAC_W + 3;            // stored weight width
  localparam int RW = DATA_W + 3;            // stored row result width
  localparam int AW = 2*FRAC_W + 6;          // weight generation width
  localparam int SW = FRAC_W + DATA_W + 6;   // row accumulator width
  localparam int CW = FRAC_W + DATA_W + 8;   // column accumulator width

  localparam logic signed [AW-1:0] C_ONE  = {{(AW-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [AW-1:0] C_HALF = {{(AW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [AW-1:0] C_1    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] S_HALF = {{(SW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [CW-1:0] V_HALF = {{(CW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [CW-1:0] V_MAX  = {{(CW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_WX, S_WY, S_ROW, S_COL, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_cnt;
  logic [16*DATA_W-1:0]  r_pix;
  logic [FRAC_W-1:0]     r_fx, r_fy;
  logic signed [WW-1:0]  r_wx [4];
  logic signed [WW-1:0]  r_wy [4];
  logic signed [RW-1:0]  r_row [4];
  logic [DATA_W-1:0]     r_out;
`ifdef BICUBIC_BILINEAR_MODE_EN
  logic                  r_mode;
`endif

  logic                  w_accept;
  logic                  w_bil;
  logic [FRAC_W-1:0]     w_t;
  logic signed [AW-1:0]  w_tt, w_t2, w_t3;
  logic signed [AW-1:0]  w_n [4];
  logic signed [WW-1:0]  w_w [4];
  logic signed [SW-1:0]  w_s;
  logic signed [RW-1:0]  w_rrow;
  logic signed [CW-1:0]  w_v, w_vr;
  logic [DATA_W-1:0]     w_clamp;

  assign w_accept      = bus.in_valid && (r_state == S_IDLE);
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_pix   = r_out;

`ifdef BICUBIC_BILINEAR_MODE_EN
  assign w_bil = r_mode;
`else
  assign w_bil = 1'b0;
`endif

  // State register; reset wins over every other event.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: fixed walk through the job, DONE waits for out_ready.
  always_comb begin
    // NOTE: default first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_WX;
      S_WX:    w_next = S_WY;
      S_WY:    w_next = S_ROW;
      S_ROW:   if (r_cnt == 2'd3) w_next = S_COL;
      S_COL:   w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Weight generator: shared by WX (t = fx) and WY (t = fy).
  always_comb begin
    w_t  = (r_state == S_WY) ? r_fy : r_fx;
    w_tt = signed'({{(AW-FRAC_W){1'b0}}, w_t});
    w_t2 = (w_tt * w_tt + C_HALF) >>> FRAC_W;
    w_t3 = (w_t2 * w_tt + C_HALF) >>> FRAC_W;
    if (w_bil) begin
      // Doubled so the shared halving step below yields ONE-t and t exactly.
      w_n[0] = '0;
      w_n[1] = (C_ONE - w_tt) <<< 1;
      w_n[2] = w_tt <<< 1;
      w_n[3] = '0;
    end else begin
      w_n[0] = -w_t3 + (w_t2 <<< 1) - w_tt;
      w_n[1] = (w_t3 <<< 1) + w_t3 - ((w_t2 <<< 2) + w_t2) + (C_ONE <<< 1);
      w_n[2] = -((w_t3 <<< 1) + w_t3) + (w_t2 <<< 2) + w_tt;
      w_n[3] = w_t3 - w_t2;
    end
    for (int k = 0; k < 4; k++) w_w[k] = WW'((w_n[k] + C_1) >>> 1);
  end

  // Horizontal pass for the row selected by r_cnt.
  always_comb begin
    w_s = '0;
    for (int i = 0; i < 4; i++)
      w_s = w_s + SW'(r_wx[i]) *
            SW'(signed'({1'b0, r_pix[(int'(r_cnt)*4 + i)*DATA_W +: DATA_W]}));
    w_rrow = RW'((w_s + S_HALF) >>> FRAC_W);
  end

  // Vertical pass with rounding and clamp to the pixel range.
  always_comb begin
    w_v = '0;
    for (int j = 0; j < 4; j++) w_v = w_v + CW'(r_wy[j]) * CW'(r_row[j]);
    w_vr = (w_v + V_HALF) >>> FRAC_W;
    if (w_vr[CW-1])        w_clamp = '0;
    else if (w_vr > V_MAX) w_clamp = {DATA_W{1'b1}};
    else                   w_clamp = w_vr[DATA_W-1:0];
  end

  // Datapath registers: input latch, weights, row results, output pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: small register arrays cleared explicitly; a reset mid-job must
      // leave no stale weights or rows behind.
      r_cnt <= '0;
      r_pix <= '0;
      r_fx  <= '0;
      r_fy  <= '0;
      r_out <= '0;
`ifdef BICUBIC_BILINEAR_MODE_EN
      r_mode <= 1'b0;
`endif
      for (int k = 0; k < 4; k++) begin
        r_wx[k]  <= '0;
        r_wy[k]  <= '0;
        r_row[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_pix <= bus.in_pix;
        r_fx  <= bus.in_fx;
        r_fy  <= bus.in_fy;
        r_cnt <= '0;
`ifdef BICUBIC_BILINEAR_MODE_EN
        r_mode <= bus.in_mode;
`endif
      end
      case (r_state)
        S_WX:  for (int k = 0; k < 4; k++) r_wx[k] <= w_w[k];
        S_WY:  for (int k = 0; k < 4; k++) r_wy[k] <= w_w[k];
        S_ROW: begin
          r_row[r_cnt] <= w_rrow;
          r_cnt        <= r_cnt + 2'd1;
        end
        S_COL: r_out <= w_clamp;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bicubic_interp_2d.sv
// Self-checking bench for bicubic_interp_2d (DATA_W = FRAC_W = 8).
// Directed windows with hand-computed results, an integer reference model
// consulted by a single compare process, backpressure and mid-job reset.
module tb_bicubic_interp_2d;
  localparam int DW  = 8;
  localparam int FW  = 8;
  localparam int ONE = 1 << FW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bicubic_interp_2d_if #(.DATA_W(DW), .FRAC_W(FW)) bus ();
  bicubic_interp_2d #(.DATA_W(DW), .FRAC_W(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int exp; int lit; longint acc; string name; } job_t;
  job_t   q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  logic   prev_valid = 1'b0;
  bit     rnd_ready  = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Catmull-Rom weight k for phase t, or bilinear when mode != 0.
  function automatic int wgt(input int t, input int k, input int mode);
    int t2, t3, n;
    if (mode != 0) return (k == 1) ? ONE - t : (k == 2) ? t : 0;
    t2 = (t*t + ONE/2) >>> FW;
    t3 = (t2*t + ONE/2) >>> FW;
    case (k)
      0:       n = -t3 + 2*t2 - t;
      1:       n = 3*t3 - 5*t2 + 2*ONE;
      2:       n = -3*t3 + 4*t2 + t;
      default: n = t3 - t2;
    endcase
    return (n + 1) >>> 1;
  endfunction

  function automatic int model(input logic [16*DW-1:0] pix, input int fx, input int fy,
                               input int mode);
    int r[4];
    int s, v;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += wgt(fx, i, mode) * int'(pix[(4*j+i)*DW +: DW]);
      r[j] = (s + ONE/2) >>> FW;
    end
    v = 0;
    for (int j = 0; j < 4; j++) v += wgt(fy, j, mode) * r[j];
    v = (v + ONE/2) >>> FW;
    if (v < 0) return 0;
    if (v > (1 << DW) - 1) return (1 << DW) - 1;
    return v;
  endfunction

  // Every row equal to [a, b, c, d].
  function automatic logic [16*DW-1:0] rows4(input int a, input int b, input int c, input int d);
    logic [16*DW-1:0] p;
    for (int j = 0; j < 4; j++) begin
      p[(4*j+0)*DW +: DW] = DW'(a);
      p[(4*j+1)*DW +: DW] = DW'(b);
      p[(4*j+2)*DW +: DW] = DW'(c);
      p[(4*j+3)*DW +: DW] = DW'(d);
    end
    return p;
  endfunction

  function automatic logic [16*DW-1:0] rand_pix();
    logic [16*DW-1:0] p;
    for (int k = 0; k < 16; k++) p[k*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    return p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle out of reset, check the result channel.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (q.size() == 0) begin
        check("idle_no_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        if (!prev_valid) check({q[0].name, "_latency"}, cyc - q[0].acc, 7);
        check({q[0].name, "_model"}, bus.out_pix, q[0].exp);
        check({q[0].name, "_busy_ready"}, bus.in_ready, 0);
        if (bus.out_ready) begin
          if (q[0].lit >= 0) check({q[0].name, "_literal"}, bus.out_pix, q[0].lit);
          void'(q.pop_front());
        end
      end
      prev_valid <= bus.out_valid && !bus.out_ready;
    end
  end

  task automatic send(input string name, input logic [16*DW-1:0] pix, input int fx,
                      input int fy, input int mode, input int lit);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    check({name, "_ready_to_accept"}, ok, 1);
    if (!ok) return;
    bus.in_pix   = pix;
    bus.in_fx    = FW'(fx);
    bus.in_fy    = FW'(fy);
`ifdef BICUBIC_BILINEAR_MODE_EN
    bus.in_mode  = mode[0];
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_pix   = rand_pix();
    q.push_back('{exp: model(pix, fx, fy, mode), lit: lit, acc: cyc, name: name});
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && q.size() > 0; n++) begin
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
    check("job_completed", q.size(), 0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic [16*DW-1:0] p;
    logic [DW-1:0]    held;
    bit               seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_pix = '0; bus.in_fx = '0; bus.in_fy = '0;
    bus.out_ready = 1'b1;
`ifdef BICUBIC_BILINEAR_MODE_EN
    bus.in_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pix", bus.out_pix, 0);
    rst_n = 1'b1;

    // Pin the reference model to hand-derived values.
    check("pin_w0_half", wgt(128, 0, 0), -16);
    check("pin_w1_half", wgt(128, 1, 0), 144);
    check("pin_w2_half", wgt(128, 2, 0), 144);
    check("pin_w3_half", wgt(128, 3, 0), -16);
    check("pin_model_edge", model(rows4(0, 0, 255, 255), 128, 0, 0), 128);
    check("pin_model_lo", model(rows4(255, 0, 0, 255), 128, 0, 0), 0);

    p = rand_pix();
    p[5*DW +: DW] = 8'h5A;
    send("identity", p, 0, 0, 0, 8'h5A);                     wait_done();
    send("flat_half", rows4(100, 100, 100, 100), 128, 128, 0, 100); wait_done();
    send("edge", rows4(0, 0, 255, 255), 128, 0, 0, 128);       wait_done();
    send("clamp_lo", rows4(255, 0, 0, 255), 128, 0, 0, 0);     wait_done();
    send("clamp_hi", rows4(0, 255, 255, 0), 128, 0, 0, 255);   wait_done();

    // Backpressure: result held 5 cycles, a second request is refused.
    bus.out_ready = 1'b0;
    p = rand_pix();
    send("backpress", p, 77, 200, 0, -1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("bp_valid_seen", seen, 1);
    held = bus.out_pix;
    for (int n = 0; n < 5; n++) begin
      bus.in_pix = rand_pix(); bus.in_fx = 8'd10; bus.in_fy = 8'd20;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("bp_stable", bus.out_pix, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();
    repeat (12) @(posedge clk);

    // Reset during the row pass aborts the job.
    send("reset_abort", rand_pix(), 90, 30, 0, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_pix", bus.out_pix, 0);
    check("abort_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);

`ifdef BICUBIC_BILINEAR_MODE_EN
    send("bilinear", rows4(0, 0, 200, 0), 64, 0, 1, 50);     wait_done();
`endif

    // Random windows and phases with random consumer stalls.
    rnd_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      send("random", rand_pix(), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           0, -1);
      wait_done();
    end
    rnd_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
